// File: rtl/double_buffer_ctrl.sv
// double_buffer_ctrl: ping-pong sequencer for the two-bank tile buffer that feeds
// the W4A8 GEMM compute array. The load engine fills one bank while the compute
// array drains the other, and tiles are consumed strictly in load order.
// Optional feature macro: DBUF_PERF_CNT_EN adds saturating stall/starve counters.
module double_buffer_ctrl #(
  parameter int BUFFER_DEPTH = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int LEN_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cfg_tile_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  comp_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  buffer_sel_load,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  buffer_sel_comp,
  output logic                  tile_loaded,
  output logic                  tile_done,
  output logic [1:0]            bank_full,
  output logic                  busy
`ifdef DBUF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_load_stall,
  output logic [31:0]           perf_comp_starve
`endif
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_LOAD    = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_COMPUTE = 2'd3
  } bank_state_t;

  bank_state_t           bank_st_q [2];
  bank_state_t           bank_st_d [2];
  logic [LEN_WIDTH-1:0]  len_q [2];
  logic [LEN_WIDTH-1:0]  len_d [2];
  logic                  lp_q, lp_d;
  logic                  cp_q, cp_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  tile_loaded_q, tile_loaded_d;
  logic                  tile_done_q, tile_done_d;

  logic                  accept;
  logic                  load_last;
  logic                  cp_has_tile;
  logic                  rd_fire;
  logic                  rd_last;
  logic [LEN_WIDTH-1:0]  cfg_len_eff;
  logic [LEN_WIDTH-1:0]  load_len;

  // Zero or oversized tile lengths mean "fill the whole bank"
  always_comb begin
    cfg_len_eff = cfg_tile_len;
    if (cfg_tile_len == '0 || cfg_tile_len > LEN_WIDTH'(BUFFER_DEPTH)) begin
      cfg_len_eff = LEN_WIDTH'(BUFFER_DEPTH);
    end
  end

  // Handshake decode: a bank still EMPTY takes its length from the live config
  always_comb begin
    accept      = in_valid & in_ready_q;
    load_len    = (bank_st_q[lp_q] == BANK_EMPTY) ? cfg_len_eff : len_q[lp_q];
    load_last   = accept & ((LEN_WIDTH'(wr_cnt_q) + LEN_WIDTH'(1)) == load_len);
    cp_has_tile = (bank_st_q[cp_q] == BANK_FULL) | (bank_st_q[cp_q] == BANK_COMPUTE);
    rd_fire     = comp_ready & cp_has_tile & (LEN_WIDTH'(rd_cnt_q) < len_q[cp_q]);
    rd_last     = rd_fire & ((LEN_WIDTH'(rd_cnt_q) + LEN_WIDTH'(1)) == len_q[cp_q]);
  end

  // Next-state: load and compute act on different banks, so their updates never overlap
  always_comb begin
    bank_st_d[0]  = bank_st_q[0];
    bank_st_d[1]  = bank_st_q[1];
    len_d[0]      = len_q[0];
    len_d[1]      = len_q[1];
    lp_d          = lp_q;
    cp_d          = cp_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    tile_loaded_d = load_last;
    tile_done_d   = rd_last;

    if (accept) begin
      if (bank_st_q[lp_q] == BANK_EMPTY) begin
        len_d[lp_q]     = cfg_len_eff;
        bank_st_d[lp_q] = BANK_LOAD;
      end
      if (load_last) begin
        bank_st_d[lp_q] = BANK_FULL;
        wr_cnt_d        = '0;
        lp_d            = ~lp_q;
      end else begin
        wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
      end
    end

    if (rd_fire) begin
      bank_st_d[cp_q] = BANK_COMPUTE;
      if (rd_last) begin
        bank_st_d[cp_q] = BANK_EMPTY;
        rd_cnt_d        = '0;
        cp_d            = ~cp_q;
      end else begin
        rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
      end
    end

    in_ready_d = (bank_st_d[lp_d] == BANK_EMPTY) | (bank_st_d[lp_d] == BANK_LOAD);
  end

  // State registers; reset discards in-flight tiles and restarts from bank 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b] <= BANK_EMPTY;
        len_q[b]     <= '0;
      end
      lp_q          <= 1'b0;
      cp_q          <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      in_ready_q    <= 1'b0;
      tile_loaded_q <= 1'b0;
      tile_done_q   <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        bank_st_q[b] <= bank_st_d[b];
        len_q[b]     <= len_d[b];
      end
      lp_q          <= lp_d;
      cp_q          <= cp_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      in_ready_q    <= in_ready_d;
      tile_loaded_q <= tile_loaded_d;
      tile_done_q   <= tile_done_d;
    end
  end

  // Output mapping to the buffer ports and status flags
  always_comb begin
    in_ready        = in_ready_q;
    wr_en           = accept;
    wr_addr         = wr_cnt_q;
    buffer_sel_load = lp_q;
    rd_en           = rd_fire;
    rd_addr         = rd_cnt_q;
    buffer_sel_comp = cp_q;
    tile_loaded     = tile_loaded_q;
    tile_done       = tile_done_q;
    bank_full[0]    = (bank_st_q[0] == BANK_FULL) | (bank_st_q[0] == BANK_COMPUTE);
    bank_full[1]    = (bank_st_q[1] == BANK_FULL) | (bank_st_q[1] == BANK_COMPUTE);
    busy            = (bank_st_q[0] != BANK_EMPTY) | (bank_st_q[1] != BANK_EMPTY);
  end

`ifdef DBUF_PERF_CNT_EN
  logic [31:0] load_stall_q, load_stall_d;
  logic [31:0] comp_starve_q, comp_starve_d;

  // Saturating counters of load back-pressure and compute starvation cycles
  always_comb begin
    load_stall_d  = load_stall_q;
    comp_starve_d = comp_starve_q;
    if (in_valid && !in_ready_q && load_stall_q != '1) begin
      load_stall_d = load_stall_q + 32'd1;
    end
    if (comp_ready && !rd_fire && comp_starve_q != '1) begin
      comp_starve_d = comp_starve_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_stall_q  <= '0;
      comp_starve_q <= '0;
    end else begin
      load_stall_q  <= load_stall_d;
      comp_starve_q <= comp_starve_d;
    end
  end

  assign perf_load_stall  = load_stall_q;
  assign perf_comp_starve = comp_starve_q;
`endif

endmodule

// File: tb/tb_double_buffer_ctrl.sv
// tb_double_buffer_ctrl: randomized scoreboard bench for double_buffer_ctrl.
// The reference model tracks tiles as whole units (tiles planned, words written,
// tiles fully loaded, tiles fully read) and derives every expected flag from
// those counts. Define DBUF_PERF_CNT_EN to also check the performance counters.
module tb_double_buffer_ctrl;

  localparam int BUFFER_DEPTH = 16;
  localparam int ADDR_WIDTH   = 4;
  localparam int LEN_WIDTH    = 5;

  logic                  clk;
  logic                  rst;
  logic [LEN_WIDTH-1:0]  cfg_tile_len;
  logic                  in_valid;
  logic                  in_ready;
  logic                  comp_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  buffer_sel_load;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  buffer_sel_comp;
  logic                  tile_loaded;
  logic                  tile_done;
  logic [1:0]            bank_full;
  logic                  busy;
`ifdef DBUF_PERF_CNT_EN
  logic [31:0]           perf_load_stall;
  logic [31:0]           perf_comp_starve;
`endif

  double_buffer_ctrl #(
    .BUFFER_DEPTH(BUFFER_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_tile_len    (cfg_tile_len),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .comp_ready      (comp_ready),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .buffer_sel_load (buffer_sel_load),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .buffer_sel_comp (buffer_sel_comp),
    .tile_loaded     (tile_loaded),
    .tile_done       (tile_done),
    .bank_full       (bank_full),
    .busy            (busy)
`ifdef DBUF_PERF_CNT_EN
    ,
    .perf_load_stall (perf_load_stall),
    .perf_comp_starve(perf_comp_starve)
`endif
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  bit checkEn    = 1'b0;

  // Scoreboard queues: expected {bank, addr} of every write and every read
  int wrQ[$];
  int rdQ[$];
  int lenArr[$];
  int plannedTiles = 0;
  int loadsDone    = 0;
  int readsDone    = 0;
  int wordsInTile  = 0;
  int readsInTile  = 0;
  bit prevLoadLast = 1'b0;
  bit prevReadLast = 1'b0;
  logic [LEN_WIDTH-1:0] planCfg = '0;
`ifdef DBUF_PERF_CNT_EN
  int mStall  = 0;
  int mStarve = 0;
`endif

  // One comparison: counts it, and reports a mismatch with both values
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      if (errorCount <= 60) begin
        $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ":in_ready"}, in_ready, 0);
    checkOutput({tag, ":wr_en"}, wr_en, 0);
    checkOutput({tag, ":wr_addr"}, wr_addr, 0);
    checkOutput({tag, ":sel_load"}, buffer_sel_load, 0);
    checkOutput({tag, ":rd_en"}, rd_en, 0);
    checkOutput({tag, ":rd_addr"}, rd_addr, 0);
    checkOutput({tag, ":sel_comp"}, buffer_sel_comp, 0);
    checkOutput({tag, ":tile_loaded"}, tile_loaded, 0);
    checkOutput({tag, ":tile_done"}, tile_done, 0);
    checkOutput({tag, ":bank_full"}, bank_full, 0);
    checkOutput({tag, ":busy"}, busy, 0);
`ifdef DBUF_PERF_CNT_EN
    checkOutput({tag, ":perf_load_stall"}, perf_load_stall, 0);
    checkOutput({tag, ":perf_comp_starve"}, perf_comp_starve, 0);
`endif
  endtask

  task automatic clearModel();
    wrQ.delete();
    rdQ.delete();
    lenArr.delete();
    plannedTiles = 0;
    loadsDone    = 0;
    readsDone    = 0;
    wordsInTile  = 0;
    readsInTile  = 0;
    prevLoadLast = 1'b0;
    prevReadLast = 1'b0;
`ifdef DBUF_PERF_CNT_EN
    mStall  = 0;
    mStarve = 0;
`endif
  endtask

  // Asynchronous reset in mid-cycle with the inputs still active, then restart
  task automatic doReset();
    #2;
    checkEn = 1'b0;
    rst = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    in_valid   = 1'b0;
    comp_ready = 1'b0;
    clearModel();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkEn = 1'b1;
  endtask

  // Drive one phase: plans tiles into the scoreboard and randomizes the handshakes
  task automatic applyStimulus(input int nTiles, input int cfgSel, input int validPct,
                               input int compPct, input int holdComp, input int abortAt);
    int made = 0;
    int cyc  = 0;
    int effLen;
    forever begin
      @(posedge clk); #1;
      if (abortAt > 0 && wordsInTile >= abortAt) break;
      if (made >= nTiles && plannedTiles == loadsDone && loadsDone == readsDone && wordsInTile == 0) begin
        in_valid = 1'b0;
        break;
      end
      if (cyc >= 5000) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL phase_timeout actual=%0d tiles_read expected=%0d", readsDone, plannedTiles);
        in_valid = 1'b0;
        break;
      end
      if (made < nTiles && plannedTiles == loadsDone) begin
        planCfg = (cfgSel >= 0) ? LEN_WIDTH'(cfgSel) : LEN_WIDTH'($urandom_range(0, 31));
        effLen  = (planCfg == 0 || int'(planCfg) > BUFFER_DEPTH) ? BUFFER_DEPTH : int'(planCfg);
        for (int a = 0; a < effLen; a++) begin
          wrQ.push_back(((plannedTiles % 2) << ADDR_WIDTH) | a);
          rdQ.push_back(((plannedTiles % 2) << ADDR_WIDTH) | a);
        end
        lenArr.push_back(effLen);
        plannedTiles++;
        made++;
      end
      if (plannedTiles > loadsDone && wordsInTile == 0) cfg_tile_len = planCfg;
      else cfg_tile_len = LEN_WIDTH'($urandom_range(0, 31));
      in_valid   = (plannedTiles > loadsDone) && ($urandom_range(0, 99) < validPct);
      comp_ready = (cyc >= holdComp) && ($urandom_range(0, 99) < compPct);
      cyc++;
    end
  endtask

  // Monitor: mid-cycle comparison of every output against the tile-level model,
  // popping the scoreboard whenever the DUT issues a write or a read
  always @(negedge clk) begin
    if (checkEn) begin
      bit       expReady;
      bit       expRd;
      bit       expBusy;
      logic [1:0] expFull;
      int       e;
      expReady = (loadsDone - readsDone) < 2;
      expRd    = comp_ready && (loadsDone > readsDone);
      expBusy  = (loadsDone > readsDone) || (wordsInTile > 0);
      expFull  = 2'b00;
      for (int t = readsDone; t < loadsDone; t++) expFull[t % 2] = 1'b1;

      checkOutput("in_ready", in_ready, expReady);
      checkOutput("wr_en", wr_en, in_valid && expReady);
      checkOutput("rd_en", rd_en, expRd);
      checkOutput("tile_loaded", tile_loaded, prevLoadLast);
      checkOutput("tile_done", tile_done, prevReadLast);
      checkOutput("bank_full", bank_full, expFull);
      checkOutput("busy", busy, expBusy);
`ifdef DBUF_PERF_CNT_EN
      checkOutput("perf_load_stall", perf_load_stall, mStall);
      checkOutput("perf_comp_starve", perf_comp_starve, mStarve);
      if (in_valid && !expReady) mStall++;
      if (comp_ready && !expRd) mStarve++;
`endif
      prevLoadLast = 1'b0;
      prevReadLast = 1'b0;

      if (wr_en) begin
        if (wrQ.size() == 0) begin
          checkOutput("wr_unexpected", {buffer_sel_load, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          e = wrQ.pop_front();
          checkOutput("wr_bank_addr", {buffer_sel_load, wr_addr}, e);
        end
        wordsInTile++;
        if (loadsDone < lenArr.size() && wordsInTile == lenArr[loadsDone]) begin
          loadsDone++;
          wordsInTile  = 0;
          prevLoadLast = 1'b1;
        end
      end

      if (rd_en) begin
        if (rdQ.size() == 0) begin
          checkOutput("rd_unexpected", {buffer_sel_comp, rd_addr}, 32'hFFFF_FFFF);
        end else begin
          e = rdQ.pop_front();
          checkOutput("rd_bank_addr", {buffer_sel_comp, rd_addr}, e);
        end
        readsInTile++;
        if (readsDone < lenArr.size() && readsInTile == lenArr[readsDone]) begin
          readsDone++;
          readsInTile  = 0;
          prevReadLast = 1'b1;
        end
      end
    end
  end

  // Main sequence of directed-shape phases with randomized handshakes
  initial begin
    rst          = 1'b0;
    in_valid     = 1'b0;
    comp_ready   = 1'b0;
    cfg_tile_len = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("por");
    rst = 1'b1;
    @(posedge clk); #1;
    checkEn = 1'b1;

    $display("[TB] single tile len=4, compute held off");
    applyStimulus(1, 4, 100, 100, 12, 0);
    $display("[TB] three tiles len=16, both banks fill before compute");
    applyStimulus(3, 16, 100, 100, 50, 0);
    $display("[TB] overlapped streams len=8");
    applyStimulus(6, 8, 100, 100, 0, 0);
    $display("[TB] comp_ready toggling, len=6");
    applyStimulus(2, 6, 100, 50, 0, 0);
    $display("[TB] cfg_tile_len=0 means a full bank");
    applyStimulus(2, 0, 100, 100, 0, 0);
    $display("[TB] fully random tiles");
    for (int p = 0; p < 4; p++) begin
      applyStimulus(6, -1, $urandom_range(30, 100), $urandom_range(30, 100), 0, 0);
    end
    $display("[TB] reset during load");
    applyStimulus(1, 8, 100, 0, 0, 5);
    doReset();
    applyStimulus(2, 5, 100, 100, 0, 0);
    $display("[TB] forced-full stall");
    applyStimulus(3, 3, 100, 100, 20, 0);

    in_valid   = 1'b0;
    comp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
